// File: rtl/mc_controller.sv
//==============================================================================
// Module      : mc_controller
// Description : Moore-FSM control unit for a multicycle RV32I-subset datapath
//               (lw, sw, R-type, I-type ALU, jal, beq). Define MC_BNE_EN to
//               also take bne branches (funct_3 = 001).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct_3,
    input  logic       funct_7,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_dec;
    logic       w_branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Bit 30 only selects sub for register-register ops; addi ignores it.
    always_comb begin
        w_alu_dec = c_ALU_ADD;
        case (funct_3)
            3'b000:  w_alu_dec = (op_code[5] & funct_7) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_dec = c_ALU_SLT;
            3'b110:  w_alu_dec = c_ALU_OR;
            3'b111:  w_alu_dec = c_ALU_AND;
            default: w_alu_dec = c_ALU_ADD;
        endcase
    end

`ifdef MC_BNE_EN
    always_comb begin
        w_branch_taken = 1'b0;
        case (funct_3)
            3'b000:  w_branch_taken = zero;
            3'b001:  w_branch_taken = ~zero;
            default: w_branch_taken = 1'b0;
        endcase
    end
`else
    assign w_branch_taken = zero;
`endif

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECUTER;
                    c_OP_I:           w_next = S_EXECUTEI;
                    c_OP_JAL:         w_next = S_JAL;
                    c_OP_BEQ:         w_next = S_BEQ;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = op_code[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = c_ALU_ADD;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op_code)
                    c_OP_LW, c_OP_SW, c_OP_R, c_OP_I, c_OP_JAL, c_OP_BEQ: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_dec;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_dec;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = c_ALU_SUB;
                pc_write    = w_branch_taken;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode in every state so DECODE sees it.
    always_comb begin
        imm_src = 2'b00;
        case (op_code)
            c_OP_SW:  imm_src = 2'b01;
            c_OP_BEQ: imm_src = 2'b10;
            c_OP_JAL: imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
//==============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op_code;
    logic [2:0] funct_3;
    logic       funct_7;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op_code    (op_code),
        .funct_3    (funct_3),
        .funct_7    (funct_7),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_control(alu_control),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [16:0] w_obs = {pc_write, adr_src, mem_write, ir_write, result_src,
                         alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal};

    // State sequence each instruction class walks through, FETCH first.
    function automatic void build_seq(input logic [6:0] op, output int s[6], output int n);
        s = '{0, 0, 0, 0, 0, 0};
        case (op)
            7'b0000011: begin s = '{0, 1, 2, 3, 4, 0};  n = 5; end
            7'b0100011: begin s = '{0, 1, 2, 5, 0, 0};  n = 4; end
            7'b0110011: begin s = '{0, 1, 6, 7, 0, 0};  n = 4; end
            7'b0010011: begin s = '{0, 1, 8, 7, 0, 0};  n = 4; end
            7'b1101111: begin s = '{0, 1, 9, 7, 0, 0};  n = 4; end
            7'b1100011: begin s = '{0, 1, 10, 0, 0, 0}; n = 3; end
            default:    begin s = '{0, 1, 0, 0, 0, 0};  n = 2; end
        endcase
    endfunction

    function automatic bit supported(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
    endfunction

    // Expected output vector for a given state from the per-state output table.
    function automatic logic [16:0] exp_out(input int st, input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7, input logic z);
        logic       pw, as, mw, iw, rw, il, bt;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu, dec;
        pw = 0; as = 0; mw = 0; iw = 0; rw = 0; il = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        if (f3 == 3'b000)      dec = (op[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) dec = 3'b101;
        else if (f3 == 3'b110) dec = 3'b011;
        else if (f3 == 3'b111) dec = 3'b010;
        else                   dec = 3'b000;
`ifdef MC_BNE_EN
        bt = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
`else
        bt = z;
`endif
        case (st)
            0:  begin iw = 1; sb = 2'b10; rs = 2'b10; pw = 1; end
            1:  begin sa = 2'b01; sb = 2'b01; il = !supported(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  as = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin as = 1; mw = 1; end
            6:  begin sa = 2'b10; alu = dec; end
            7:  rw = 1;
            8:  begin sa = 2'b10; sb = 2'b01; alu = dec; end
            9:  begin sa = 2'b01; sb = 2'b10; pw = 1; end
            10: begin sa = 2'b10; alu = 3'b001; pw = bt; end
            default: ;
        endcase
        return {pw, as, mw, iw, rs, sa, sb, alu, imm, rw, il};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH, comparing state and outputs each cycle.
    task automatic exec_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic z);
        int s[6];
        int n;
        logic [16:0] e;
        op_code = op; funct_3 = f3; funct_7 = f7; zero = z;
        #0;
        build_seq(op, s, n);
        for (int i = 0; i < n; i++) begin
            total++;
            if (state !== 4'(s[i])) begin
                bad++;
                $display("FAIL %s state step %0d: got %0d want %0d", nm, i, state, s[i]);
            end
            e = exp_out(s[i], op, f3, f7, z);
            total++;
            if (w_obs !== e) begin
                bad++;
                $display("FAIL %s outputs step %0d: got %b want %b", nm, i, w_obs, e);
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_code = 7'b1111111; funct_3 = 3'b000; funct_7 = 1'b0; zero = 1'b0;
        #3;
        total++;
        if (state !== 4'd0 || w_obs !== exp_out(0, op_code, 3'b000, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_hold: got state %0d out %b want state 0 out %b",
                     state, w_obs, exp_out(0, op_code, 3'b000, 1'b0, 1'b0));
        end
        step();
        step();
        total++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_edges: got state %0d illegal %b want 0 0", state, illegal);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        total++;
        if (state !== 4'd1) begin
            bad++;
            $display("FAIL reset_release: got state %0d want 1", state);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        exec_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0);
        exec_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0);
        exec_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0);
        exec_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0);
        exec_instr("or",    7'b0110011, 3'b110, 1'b0, 1'b0);
        exec_instr("andi",  7'b0010011, 3'b111, 1'b0, 1'b0);
        exec_instr("slt",   7'b0110011, 3'b010, 1'b0, 1'b0);
        exec_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0);
        exec_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1);
        exec_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0);
        exec_instr("bne",   7'b1100011, 3'b001, 1'b0, 1'b0);
        exec_instr("bne_z", 7'b1100011, 3'b001, 1'b0, 1'b1);
        exec_instr("ill",   7'b1111111, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1101111, 7'b1100011, 7'b0000000};
        logic [6:0] op;
        for (int k = 0; k < 200; k++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 7'b0000000) begin
                do op = 7'($urandom); while (supported(op));
            end
            exec_instr("rand", op, 3'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_midwrite();
        op_code = 7'b0100011; funct_3 = 3'b010; funct_7 = 1'b0; zero = 1'b0;
        step(); step(); step();
        total++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            bad++;
            $display("FAIL midwrite_pre: got state %0d mem_write %b want 5 1", state, mem_write);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL midwrite_reset: got state %0d mem_write %b want 0 0", state, mem_write);
        end
        step();
        total++;
        if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            bad++;
            $display("FAIL midwrite_hold: got state %0d mw %b rw %b want 0 0 0",
                     state, mem_write, reg_write);
        end
        @(negedge clk);
        reset = 1'b0;
        exec_instr("post_rst", 7'b0000011, 3'b010, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
- No parameters.
- REQ-001: Clocking and reset SHALL be one clock with an asynchronous, active-high reset: clk, reset.
- REQ-002: clk  input  1  rising-edge clock.
- REQ-003: reset  input  1  asynchronous active-high reset to FETCH.
- REQ-004: op_code  input  7  opcode field of the instruction register.
- REQ-005: funct_3  input  3  funct3 field of the instruction register.
- REQ-006: funct_7  input  1  instruction bit 30.
- REQ-007: zero  input  1  ALU zero flag, sampled in the BEQ state.
- REQ-008: pc_write  output  1  PC register enable.
- REQ-009: adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- REQ-010: mem_write  output  1  data memory write enable.
- REQ-011: ir_write  output  1  instruction register and old-PC register enable.
- REQ-012: result_src  output  2  result select: 00 = ALU result register, 01 = memory data register, 10 = ALU output.
- REQ-013: alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register.
- REQ-014: alu_src_b  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- REQ-015: alu_control  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- REQ-016: imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- REQ-017: reg_write  output  1  register file write enable.
- REQ-018: illegal  output  1  one-cycle pulse on an unsupported opcode.
- REQ-019: state  output  4  current FSM state, for debug and verification.

Function
- REQ-020: The controller SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10.
- REQ-021: Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR for 0000011/0100011, EXECUTER for 0110011, EXECUTEI for 0010011, JAL for 1101111, BEQ for 1100011, otherwise FETCH; MEMADR->MEMREAD when op_code[5]=0, else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
- REQ-022: Unlisted state codes (11-15) SHALL go to FETCH on the next edge.
- REQ-023: Each state SHALL drive these outputs, with every unlisted output at 0:
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_write=1.
  - DECODE: alu_src_a=01, alu_src_b=01, add.
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1.
  - EXECUTER: alu_src_a=10, alu_src_b=00, decoded operation.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, decoded operation.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=branch_taken.
- REQ-024: The decoded operation SHALL be taken from funct_3 as: 000 -> sub if op_code[5] & funct_7, else add; 010 -> slt; 110 -> or; 111 -> and; any other value -> add.
- REQ-025: imm_src SHALL be combinational from op_code in every state: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other opcode -> 00.
- REQ-026: illegal SHALL be 1 only in DECODE with an unsupported opcode, for exactly one cycle.
- REQ-027: Instruction latencies SHALL be, counting from FETCH through the last state: lw 5 cycles, sw 4, R-type and I-type 4, jal 4, beq 3.

Reset
- REQ-028: Asserting reset SHALL force state=FETCH immediately, including mid-instruction, with no partial write completing afterwards.
- REQ-029: While reset is held, outputs SHALL equal the FETCH values, with illegal=0.
- REQ-030: The first rising edge after reset deassertion SHALL advance FETCH->DECODE.

Configuration
- REQ-031: The branch condition SHALL depend on the macro MC_BNE_EN:
  - Defined: branch_taken = zero when funct_3=000 (beq); branch_taken = ~zero when funct_3=001 (bne); branch_taken = 0 for any other funct_3.
  - Undefined: branch_taken = zero, regardless of funct_3.

Verification
- REQ-032: lw (op 0000011) from reset -> states 0,1,2,3,4,0; reg_write=1 only in state 4, with result_src=01.
- REQ-033: sw (op 0100011) -> states 0,1,2,5,0; mem_write=1 and adr_src=1 only in state 5; imm_src=01 throughout.
- REQ-034: sub (op 0110011, funct_3=000, funct_7=1) -> alu_control=001 in state 6, then state 7 with reg_write=1.
- REQ-035: beq with zero=1 -> pc_write=1 in state 10; with zero=0 -> pc_write=0. With MC_BNE_EN, funct_3=001 and zero=0 -> pc_write=1.
- REQ-036: op_code=1111111 -> illegal=1 for one cycle in DECODE, then FETCH; no reg_write or mem_write is asserted.
- REQ-037: reset asserted in MEMWRITE -> state=0 and mem_write=0 in the same cycle.
